// File: rtl/rgb_expander.sv
// -----------------------------------------------------------------------------
// rgb_expander
//
// Expands a packed low-depth RGB pixel ({R,G,B}, R in the MSBs) to OUT_BITS
// per channel, through a two-stage elastic (valid/ready) pipeline.
//
// Stage 1 captures the unpacked channels, the sync sideband and the expansion
// mode of the accepted pixel. Stage 2 captures the expanded result. Each stage
// advances whenever it is empty or the stage after it is draining, so the
// pipeline runs at one pixel per clock with a fixed two-cycle latency and
// never inserts a bubble while it stalls or recovers.
//
// Expansion modes (sampled together with each pixel):
//   00 replicate  : channel bits repeated MSB-first, truncated to OUT_BITS
//   01 zero-pad   : channel left-aligned, low bits zero
//   10 grayscale  : y = (77*R' + 150*G' + 29*B') >> 8 on replicated channels,
//                   driven onto all three outputs
//   11 reserved   : treated as replicate
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset; flushes the pipeline
//   mode       expansion mode for the pixel presented this cycle
//   in_valid   in_pixel / in_sync are valid
//   in_ready   block accepts a pixel this cycle (combinational)
//   in_pixel   packed {R,G,B} input pixel
//   in_sync    {hsync, vsync, de} sideband travelling with the pixel
//   out_valid  out_rgb / out_sync are valid
//   out_ready  downstream accepts the output this cycle
//   out_rgb    expanded {R,G,B}, R in the MSBs
//   out_sync   sideband aligned with out_rgb
// -----------------------------------------------------------------------------
module rgb_expander #(
  parameter int R_BITS   = 3,
  parameter int G_BITS   = 3,
  parameter int B_BITS   = 2,
  parameter int OUT_BITS = 8
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [1:0]                       mode,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [R_BITS+G_BITS+B_BITS-1:0]  in_pixel,
  input  logic [2:0]                       in_sync,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [3*OUT_BITS-1:0]            out_rgb,
  output logic [2:0]                       out_sync
);

  localparam int IN_W  = R_BITS + G_BITS + B_BITS;
  // Grayscale coefficients sum to 256, so the weighted sum needs 8 extra bits.
  localparam int SUM_W = OUT_BITS + 8;

  // Number of whole copies needed so replication covers OUT_BITS.
  localparam int R_REP = (OUT_BITS + R_BITS - 1) / R_BITS;
  localparam int G_REP = (OUT_BITS + G_BITS - 1) / G_BITS;
  localparam int B_REP = (OUT_BITS + B_BITS - 1) / B_BITS;

  typedef enum logic [1:0] {
    MODE_REPLICATE = 2'b00,
    MODE_ZERO_PAD  = 2'b01,
    MODE_GRAY      = 2'b10,
    MODE_RESERVED  = 2'b11
  } mode_e;

  // ---------------------------------------------------------------------------
  // Handshake / stage enables
  // ---------------------------------------------------------------------------
  logic v1, v2;
  logic en1, en2;

  assign en2      = !v2 || out_ready;
  assign en1      = !v1 || en2;
  assign in_ready = en1;

  // ---------------------------------------------------------------------------
  // Stage 1: unpacked channels, sideband and mode
  // ---------------------------------------------------------------------------
  logic [R_BITS-1:0] r1;
  logic [G_BITS-1:0] g1;
  logic [B_BITS-1:0] b1;
  logic [2:0]        sync1;
  mode_e             mode1;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the values from before the clock edge.
  // NOTE: data registers are reset as well as the valid bits, so no stale pixel
  // data is visible on the outputs after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v1    <= 1'b0;
      r1    <= '0;
      g1    <= '0;
      b1    <= '0;
      sync1 <= '0;
      mode1 <= MODE_REPLICATE;
    end else if (en1) begin
      v1 <= in_valid;
      // Payload only moves on a real transfer; idle inputs are ignored.
      if (in_valid) begin
        r1    <= in_pixel[IN_W-1 -: R_BITS];
        g1    <= in_pixel[B_BITS +: G_BITS];
        b1    <= in_pixel[B_BITS-1:0];
        sync1 <= in_sync;
        mode1 <= mode_e'(mode);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Channel expansion (combinational, from stage 1)
  // ---------------------------------------------------------------------------
  logic [R_REP*R_BITS-1:0] r_wide;
  logic [G_REP*G_BITS-1:0] g_wide;
  logic [B_REP*B_BITS-1:0] b_wide;
  logic [OUT_BITS-1:0]     r_rep, g_rep, b_rep;
  logic [OUT_BITS-1:0]     r_zp, g_zp, b_zp;
  logic [SUM_W-1:0]        gray_sum;
  logic [OUT_BITS-1:0]     gray;

  // Replicate: concatenate enough copies, keep the top OUT_BITS.
  assign r_wide = {R_REP{r1}};
  assign g_wide = {G_REP{g1}};
  assign b_wide = {B_REP{b1}};
  assign r_rep  = OUT_BITS'(r_wide >> (R_REP*R_BITS - OUT_BITS));
  assign g_rep  = OUT_BITS'(g_wide >> (G_REP*G_BITS - OUT_BITS));
  assign b_rep  = OUT_BITS'(b_wide >> (B_REP*B_BITS - OUT_BITS));

  // Zero-pad: left-align; a zero shift when N == OUT_BITS passes it through.
  assign r_zp = OUT_BITS'(r1) << (OUT_BITS - R_BITS);
  assign g_zp = OUT_BITS'(g1) << (OUT_BITS - G_BITS);
  assign b_zp = OUT_BITS'(b1) << (OUT_BITS - B_BITS);

  // Luma on the replicated channels; the sum is wide enough never to wrap.
  assign gray_sum = SUM_W'(77)  * SUM_W'(r_rep)
                  + SUM_W'(150) * SUM_W'(g_rep)
                  + SUM_W'(29)  * SUM_W'(b_rep);
  assign gray     = OUT_BITS'(gray_sum >> 8);

  logic [3*OUT_BITS-1:0] rgb_exp;

  // NOTE: the output gets a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    rgb_exp = {r_rep, g_rep, b_rep};
    case (mode1)
      MODE_ZERO_PAD: rgb_exp = {r_zp, g_zp, b_zp};
      MODE_GRAY:     rgb_exp = {gray, gray, gray};
      default:       rgb_exp = {r_rep, g_rep, b_rep};
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 2: expanded result, held while downstream stalls
  // ---------------------------------------------------------------------------
  logic [3*OUT_BITS-1:0] rgb2;
  logic [2:0]            sync2;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v2    <= 1'b0;
      rgb2  <= '0;
      sync2 <= '0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        rgb2  <= rgb_exp;
        sync2 <= sync1;
      end
    end
  end

  assign out_valid = v2;
  assign out_rgb   = rgb2;
  assign out_sync  = sync2;

endmodule

// File: tb/tb_rgb_expander.sv
// -----------------------------------------------------------------------------
// tb_rgb_expander
//
// Self-checking bench for rgb_expander. A default (3/3/2 -> 8) instance is
// driven through directed vectors, backpressure, mode toggling, mid-stream
// reset and random traffic, all scored against a reference model computed
// from the channel arithmetic. A second 5/6/5 instance gets a sanity check.
// -----------------------------------------------------------------------------
module tb_rgb_expander;

  localparam int R = 3;
  localparam int G = 3;
  localparam int B = 2;
  localparam int O = 8;

  logic        clk;
  logic        resetn;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_pixel;
  logic [2:0]  in_sync;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_rgb;
  logic [2:0]  out_sync;

  logic [1:0]  mode2;
  logic        in_valid2;
  logic        in_ready2;
  logic [15:0] in_pixel2;
  logic [2:0]  in_sync2;
  logic        out_valid2;
  logic        out_ready2;
  logic [23:0] out_rgb2;
  logic [2:0]  out_sync2;

  rgb_expander dut (
    .clk       (clk),
    .resetn    (resetn),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .in_sync   (in_sync),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rgb   (out_rgb),
    .out_sync  (out_sync)
  );

  rgb_expander #(.R_BITS(5), .G_BITS(6), .B_BITS(5), .OUT_BITS(8)) dut565 (
    .clk       (clk),
    .resetn    (resetn),
    .mode      (mode2),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .in_pixel  (in_pixel2),
    .in_sync   (in_sync2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out_rgb   (out_rgb2),
    .out_sync  (out_sync2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] rgb;
    logic [2:0]  sync;
  } exp_t;

  exp_t        sb[$];
  logic        accepted;
  logic        held;
  logic [23:0] held_rgb;
  logic [2:0]  held_sync;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  // Replicate: keep appending the channel value until at least O bits exist,
  // then drop the excess low bits.
  function automatic int rep_m(input int c, input int n);
    int acc;
    int bits;
    acc  = 0;
    bits = 0;
    while (bits < O) begin
      acc  = acc * (2 ** n) + c;
      bits = bits + n;
    end
    return acc / (2 ** (bits - O));
  endfunction

  function automatic logic [23:0] model(input int pix, input int md);
    int r, g, b, rr, gg, bb, y;
    r = pix / (2 ** (G + B));
    g = (pix / (2 ** B)) % (2 ** G);
    b = pix % (2 ** B);
    case (md)
      1: begin
        rr = r * (2 ** (O - R));
        gg = g * (2 ** (O - G));
        bb = b * (2 ** (O - B));
      end
      2: begin
        y  = (77 * rep_m(r, R) + 150 * rep_m(g, G) + 29 * rep_m(b, B)) / 256;
        rr = y;
        gg = y;
        bb = y;
      end
      default: begin
        rr = rep_m(r, R);
        gg = rep_m(g, G);
        bb = rep_m(b, B);
      end
    endcase
    return 24'(rr * 65536 + gg * 256 + bb);
  endfunction

  // ---------------------------------------------------------------------------
  // One clock: observe handshakes mid-cycle, then advance past the edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (held) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_rgb", 32'(out_rgb), 32'(held_rgb));
      check("hold_sync", 32'(out_sync), 32'(held_sync));
    end
    held      = out_valid && !out_ready;
    held_rgb  = out_rgb;
    held_sync = out_sync;
    if (out_valid && out_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_rgb", 32'(out_rgb), 32'(e.rgb));
        check("sb_sync", 32'(out_sync), 32'(e.sync));
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) sb.push_back('{model(int'(in_pixel), int'(mode)), in_sync});
    @(posedge clk);
    #1;
  endtask

  // Single pixel through an empty pipe: latency plus a directed expected value.
  task automatic send_one(input string tag, input logic [7:0] pix, input logic [1:0] md,
                          input logic [2:0] sy, input logic [23:0] exp_rgb);
    out_ready = 1'b1;
    mode      = md;
    in_pixel  = pix;
    in_sync   = sy;
    in_valid  = 1'b1;
    step();
    check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    step();
    check({tag, "_lat2"}, 32'(out_valid), 32'd1);
    check(tag, 32'(out_rgb), 32'(exp_rgb));
    check({tag, "_sync"}, 32'(out_sync), 32'(sy));
    step();
  endtask

  logic [7:0] pk [3];
  int idx;

  initial begin
    resetn     = 1'b0;
    mode       = 2'b00;
    in_valid   = 1'b0;
    in_pixel   = '0;
    in_sync    = '0;
    out_ready  = 1'b1;
    mode2      = 2'b00;
    in_valid2  = 1'b0;
    in_pixel2  = '0;
    in_sync2   = '0;
    out_ready2 = 1'b1;
    held       = 1'b0;
    accepted   = 1'b0;
    held_rgb   = '0;
    held_sync  = '0;

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_rgb", 32'(out_rgb), 32'd0);
    check("rst_out_sync", 32'(out_sync), 32'd0);
    check("rst_out_valid565", 32'(out_valid2), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Directed expansion vectors
    send_one("rep_b6",  8'hB6, 2'b00, 3'b101, 24'hB6B6AA);
    send_one("zp_b6",   8'hB6, 2'b01, 3'b010, 24'hA0A080);
    send_one("zp_ff",   8'hFF, 2'b01, 3'b111, 24'hE0E0C0);
    send_one("gray_e0", 8'hE0, 2'b10, 3'b001, 24'h4C4C4C);
    send_one("gray_ff", 8'hFF, 2'b10, 3'b100, 24'hFFFFFF);
    send_one("gray_00", 8'h00, 2'b10, 3'b011, 24'h000000);
    send_one("rsvd_b6", 8'hB6, 2'b11, 3'b110, 24'hB6B6AA);

    // Backpressure: out_ready low for 5 cycles while offering P0..P2
    pk[0] = 8'h12;
    pk[1] = 8'h5A;
    pk[2] = 8'hC3;
    idx = 0;
    mode = 2'b00;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (idx < 3);
      in_pixel = pk[idx % 3];
      in_sync  = 3'(idx);
      step();
      if (accepted) idx++;
    end
    check("bp_accepted", 32'(idx), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = (idx < 3);
      in_pixel = pk[idx % 3];
      in_sync  = 3'(idx);
      #1;
      check("b2b_valid", 32'(out_valid), 32'd1);
      step();
      if (accepted) idx++;
    end
    in_valid = 1'b0;
    check("bp_all_in", 32'(idx), 32'd3);
    check("bp_drained", 32'(out_valid), 32'd0);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Mode toggled every cycle; outputs must alternate in input order
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      in_valid = (j < 4);
      in_pixel = 8'hB6;
      in_sync  = 3'b001;
      mode     = 2'(j % 2);
      step();
      if (j >= 1) begin
        check("tog_valid", 32'(out_valid), 32'd1);
        check("tog_rgb", 32'(out_rgb), ((j - 1) % 2 == 1) ? 32'h00A0A080 : 32'h00B6B6AA);
      end
    end
    in_valid = 1'b0;
    step();
    check("tog_sb_empty", 32'(sb.size()), 32'd0);

    // Reset with both stages full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    mode      = 2'b00;
    in_pixel  = 8'h3C;
    step();
    in_pixel  = 8'hF1;
    step();
    in_valid  = 1'b0;
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_rgb", 32'(out_rgb), 32'd0);
    sb.delete();
    held = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("no_stale", 32'(out_valid), 32'd0);
    end
    send_one("post_rst", 8'h6D, 2'b00, 3'b010, 24'h6D6D55);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      mode      = 2'($urandom_range(3));
      in_pixel  = 8'($urandom);
      in_sync   = 3'($urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("rand_sb_empty", 32'(sb.size()), 32'd0);
    check("rand_idle", 32'(out_valid), 32'd0);

    // 5/6/5 instance sanity
    mode2     = 2'b00;
    in_pixel2 = 16'hFFFF;
    in_sync2  = 3'b101;
    in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    @(posedge clk);
    #1;
    check("p565_valid", 32'(out_valid2), 32'd1);
    check("p565_rep_ffff", 32'(out_rgb2), 32'h00FFFFFF);
    check("p565_sync", 32'(out_sync2), 32'd5);
    mode2     = 2'b01;
    in_pixel2 = 16'hFFFF;
    in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    @(posedge clk);
    #1;
    check("p565_zp_ffff", 32'(out_rgb2), 32'h00F8FCF8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
